// File: rtl/color_regfile_writer.sv
// color_regfile_writer: initiator side of the color register-file write port.
// Serializes a latched 24-bit RGB color into six 4-bit four-phase writes
// (address/data/valid/ack), then pulses color_next/done to commit the color.
// Optional build macro WRITER_TIMEOUT_EN adds a per-phase ack timeout that
// aborts the transfer and raises the sticky err flag.
module color_regfile_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [23:0] rgb,
  input  logic [1:0]  ch,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [1:0]  channel,
  output logic [3:0]  address,
  output logic [3:0]  data,
  output logic        valid,
  input  logic        ack,
  output logic        color_next
);

  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE, COMMIT} state_t;

  state_t           state;
  state_t           next_state;
  logic [23:0]      color;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nibble_c;
  logic             accept_c;
  logic             advance_c;
  logic             abort_c;
  logic             timeout_hit_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; handshake edges are only honoured once our own valid
  // output has reached the level for that phase, so a stale ack is ignored.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    advance_c  = 1'b0;
    abort_c    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept_c   = 1'b1;
          next_state = DRIVE;
        end
      end
      DRIVE: begin
        if (valid && ack) begin
          next_state = RELEASE;
        end else if (timeout_hit_c) begin
          abort_c    = 1'b1;
          next_state = IDLE;
        end
      end
      RELEASE: begin
        if (!valid && !ack) begin
          if (idx < LAST_IDX) begin
            advance_c  = 1'b1;
            next_state = DRIVE;
          end else begin
            next_state = COMMIT;
          end
        end else if (timeout_hit_c) begin
          abort_c    = 1'b1;
          next_state = IDLE;
        end
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Nibble select, most significant nibble first
  always_comb begin
    case (idx)
      3'd0:    nibble_c = color[23:20];
      3'd1:    nibble_c = color[19:16];
      3'd2:    nibble_c = color[15:12];
      3'd3:    nibble_c = color[11:8];
      3'd4:    nibble_c = color[7:4];
      3'd5:    nibble_c = color[3:0];
      default: nibble_c = 4'h0;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color      <= '0;
      channel    <= '0;
      idx        <= '0;
      address    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      color_next <= 1'b0;
    end else begin
      ready      <= (next_state == IDLE);
      valid      <= (state == DRIVE) && !abort_c;
      done       <= (state == COMMIT);
      color_next <= (state == COMMIT);
      if (accept_c) begin
        color   <= rgb;
        channel <= ch;
        idx     <= '0;
      end else if (advance_c) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == DRIVE) begin
        address <= 4'(idx);
        data    <= nibble_c;
      end
    end
  end

`ifdef WRITER_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit_c = (wait_cnt == TIMEOUT_LAST);

  // Stall counter: restarts on every state change, counts cycles waiting on ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    wait_cnt <= '0;
    else if (next_state != state)                wait_cnt <= '0;
    else if (state == DRIVE || state == RELEASE) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Sticky abort flag, cleared by the next accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          err <= 1'b0;
    else if (accept_c) err <= 1'b0;
    else if (abort_c)  err <= 1'b1;
  end
`else
  // Without the timeout the block waits on ack forever and never flags err
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit_c  = 1'b0;
  assign err            = 1'b0;
`endif

endmodule
